// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin arbiter feeding one shared adder and returning tagged results
module adder_rr_scheduler #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int LAT   = 1,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_add1,
    input  logic [NREQ*WIDTH-1:0] i_req_add2,
    output logic [NREQ-1:0]       o_req_ready,
    output logic [WIDTH-1:0]      o_add1,
    output logic [WIDTH-1:0]      o_add2,
    input  logic [WIDTH:0]        i_add_result,
    output logic                  o_resp_valid,
    output logic [IDW-1:0]        o_resp_id,
    output logic [WIDTH:0]        o_resp_result,
    input  logic                  i_resp_ready,
    output logic                  o_busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int CW = LAT > 0 ? $clog2(LAT + 1) : 1;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] idx;
    logic           any;

    // search downwards so the candidate closest after ptr is the last one written
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (i_req_valid[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

    assign o_req_ready = (state == IDLE && any) ? NREQ'(1) << grant : '0;
    assign o_busy      = state != IDLE;

    // accept, wait out the adder latency, then hold the response until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= IDW'(NREQ - 1);
            cnt           <= '0;
            o_add1        <= '0;
            o_add2        <= '0;
            o_resp_valid  <= 1'b0;
            o_resp_id     <= '0;
            o_resp_result <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    o_add1    <= i_req_add1[grant*WIDTH +: WIDTH];
                    o_add2    <= i_req_add2[grant*WIDTH +: WIDTH];
                    o_resp_id <= grant;
                    ptr       <= grant;
                    cnt       <= CW'(LAT);
                    state     <= WAIT;
                end
                WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    o_resp_result <= i_add_result;
                    o_resp_valid  <= 1'b1;
                    state         <= RESP;
                end
                RESP: if (i_resp_ready) begin
                    o_resp_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed checks plus a result scoreboard for the round-robin adder scheduler
module tb_adder_rr_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    logic [3:0]  v1 = '0, rdy1;
    logic [15:0] a1 = '0, b1 = '0;
    logic [3:0]  add1_1, add2_1;
    logic [4:0]  res1 = '0, rres1;
    logic        rv1, rr1 = 1'b1, busy1;
    logic [1:0]  rid1;

    logic [3:0]  v0 = '0, rdy0;
    logic [15:0] a0 = '0, b0 = '0;
    logic [3:0]  add1_0, add2_0;
    logic [4:0]  res0, rres0;
    logic        rv0, rr0 = 1'b1, busy0;
    logic [1:0]  rid0;

    logic [6:0]  sb[$];
    logic [6:0]  e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // registered adder model for the LAT=1 instance, combinational one for LAT=0
    always @(posedge clk) res1 <= {1'b0, add1_1} + {1'b0, add2_1};
    assign res0 = {1'b0, add1_0} + {1'b0, add2_0};

    adder_rr_scheduler #(.WIDTH(4), .NREQ(4), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .i_req_valid(v1), .i_req_add1(a1), .i_req_add2(b1),
        .o_req_ready(rdy1), .o_add1(add1_1), .o_add2(add2_1), .i_add_result(res1),
        .o_resp_valid(rv1), .o_resp_id(rid1), .o_resp_result(rres1),
        .i_resp_ready(rr1), .o_busy(busy1)
    );

    adder_rr_scheduler #(.WIDTH(4), .NREQ(4), .LAT(0)) u0 (
        .clk(clk), .rst(rst), .i_req_valid(v0), .i_req_add1(a0), .i_req_add2(b0),
        .o_req_ready(rdy0), .o_add1(add1_0), .o_add2(add2_0), .i_add_result(res0),
        .o_resp_valid(rv0), .o_resp_id(rid0), .o_resp_result(rres0),
        .i_resp_ready(rr0), .o_busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int g, output int c);
        bit done = 0;
        g = -1;
        c = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (|rdy1) begin
                for (int i = 0; i < 4; i++) if (rdy1[i]) g = i;
                c = cyc;
                done = 1;
            end
        end
        if (!done) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_resp();
        bit done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = rv1;
        end
        if (!done) check("resp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            done = !busy1;
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    // push expected {id, sum} at each grant, pop and compare at each response handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (|rdy1) begin
                check("grant_onehot", 32'($onehot(rdy1)), 1);
                for (int i = 0; i < 4; i++)
                    if (rdy1[i]) sb.push_back({2'(i), {1'b0, a1[i*4 +: 4]} + {1'b0, b1[i*4 +: 4]}});
            end
            if (rv1 && rr1) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("sb_id", rid1, e[6:5]);
                    check("sb_result", rres1, e[4:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, c, prev;
        prev = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy1, 0);
        check("rst_resp_valid", rv1, 0);
        check("rst_ready", rdy1, 0);
        check("rst_add1", add1_1, 0);
        check("rst_add2", add2_1, 0);
        check("rst_resp_id", rid1, 0);
        check("rst_resp_result", rres1, 0);
        rst = 1'b0;

        // fairness: everyone valid, expect 0,1,2,3,0,1 four cycles apart
        @(posedge clk); #1;
        a1 = {4'hD, 4'h6, 4'h2, 4'hF};
        b1 = {4'h3, 4'hA, 4'h5, 4'h1};
        v1 = 4'hF;
        for (int k = 0; k < 6; k++) begin
            wait_grant(g, c);
            check("rr_order", 32'(g), 32'(k % 4));
            if (k > 0) check("rr_gap", 32'(c - prev), 4);
            prev = c;
        end
        @(posedge clk); #1;
        v1 = '0;
        wait_idle();

        // single request with full latency trace
        @(posedge clk); #1;
        a1[7:4] = 4'h9;
        b1[7:4] = 4'h8;
        v1 = 4'b0010;
        @(negedge clk);
        check("t1_ready", rdy1, 4'b0010);
        @(posedge clk); #1;
        v1 = '0;
        @(negedge clk);
        check("t1_add1", add1_1, 4'h9);
        check("t1_add2", add2_1, 4'h8);
        check("t1_busy", busy1, 1);
        @(negedge clk);
        check("t1_early_valid", rv1, 0);
        @(negedge clk);
        check("t1_valid", rv1, 1);
        check("t1_id", rid1, 1);
        check("t1_result", rres1, 5'h11);
        wait_idle();

        // backpressure: ptr=1 so req 2 wins, then req 0 after handshake
        rr1 = 1'b0;
        @(posedge clk); #1;
        a1[3:0] = 4'h3;  b1[3:0] = 4'h4;
        a1[11:8] = 4'hA; b1[11:8] = 4'h7;
        v1 = 4'b0101;
        wait_grant(g, c);
        check("bp_grant", 32'(g), 2);
        @(posedge clk); #1;
        v1[2] = 1'b0;
        wait_resp();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", rv1, 1);
            check("bp_id", rid1, 2);
            check("bp_result", rres1, 5'h11);
            check("bp_ready", rdy1, 0);
            check("bp_busy", busy1, 1);
        end
        @(posedge clk); #1;
        rr1 = 1'b1;
        @(negedge clk);
        check("bp_hs_ready", rdy1, 0);
        @(negedge clk);
        check("bp_next_grant", rdy1, 4'b0001);
        @(posedge clk); #1;
        v1[0] = 1'b0;
        wait_idle();

        // wrap: move ptr to 3, then reqs 0 and 3 contend
        @(posedge clk); #1;
        a1[15:12] = 4'h1; b1[15:12] = 4'h2;
        v1 = 4'b1000;
        wait_grant(g, c);
        check("wrap_setup", 32'(g), 3);
        @(posedge clk); #1;
        v1 = '0;
        wait_idle();
        @(posedge clk); #1;
        a1[3:0] = 4'hF;   b1[3:0] = 4'hF;
        a1[15:12] = 4'h0; b1[15:12] = 4'h0;
        v1 = 4'b1001;
        wait_grant(g, c);
        check("wrap_first", 32'(g), 0);
        @(posedge clk); #1;
        v1[0] = 1'b0;
        wait_resp();
        check("wrap_id0", rid1, 0);
        check("wrap_res0", rres1, 5'h1E);
        wait_grant(g, c);
        check("wrap_second", 32'(g), 3);
        @(posedge clk); #1;
        v1 = '0;
        wait_resp();
        check("wrap_id3", rid1, 3);
        check("wrap_res3", rres1, 5'h00);
        wait_idle();

        // reset while waiting on the adder for req 2
        @(posedge clk); #1;
        a1[11:8] = 4'h5; b1[11:8] = 4'h6;
        v1 = 4'b0100;
        wait_grant(g, c);
        check("mid_grant", 32'(g), 2);
        @(posedge clk); #1;
        v1 = '0;
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_valid", rv1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_add1", add1_1, 0);
        check("mid_rst_add2", add2_1, 0);
        check("mid_rst_id", rid1, 0);
        check("mid_rst_result", rres1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", rv1, 0);
        end
        @(posedge clk); #1;
        a1[3:0] = 4'h2; b1[3:0] = 4'h3;
        v1 = 4'b0101;
        wait_grant(g, c);
        check("post_rst_first", 32'(g), 0);
        @(posedge clk); #1;
        v1[0] = 1'b0;
        wait_grant(g, c);
        check("post_rst_second", 32'(g), 2);
        @(posedge clk); #1;
        v1 = '0;
        wait_idle();

        // zero-latency instance
        @(posedge clk); #1;
        a0[11:8] = 4'h7; b0[11:8] = 4'hC;
        v0 = 4'b0100;
        @(negedge clk);
        check("l0_ready", rdy0, 4'b0100);
        @(posedge clk); #1;
        v0 = '0;
        @(negedge clk);
        check("l0_early_valid", rv0, 0);
        check("l0_add1", add1_0, 4'h7);
        @(negedge clk);
        check("l0_valid", rv0, 1);
        check("l0_id", rid0, 2);
        check("l0_result", rres0, 5'h13);
        check("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
